// File: rtl/axil_pkg.sv
// Shared constants and types for the AXI4-Lite BRAM slave.
// Response codes, bus widths, FSM states and arbitration grant.
package axil_pkg;

  localparam int AXI_DW = 32;
  localparam int AXI_SW = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RWAIT,
    S_RRESP
  } state_e;

  typedef enum logic {
    GNT_WRITE = 1'b0,
    GNT_READ  = 1'b1
  } grant_e;

endpackage

// File: rtl/axil_bram_slave.sv
// AXI4-Lite slave in front of a single-port 32-bit BRAM.
// One access in flight; contested AW/W vs AR is round-robin.
module axil_bram_slave
  import axil_pkg::*;
#(
  parameter int unsigned BRAM_AW   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic [31:0]       bram_axi_awaddr_i,
  input  logic              bram_axi_awvalid_i,
  output logic              bram_axi_awready_o,
  input  logic [AXI_DW-1:0] bram_axi_wdata_i,
  input  logic [AXI_SW-1:0] bram_axi_wstrb_i,
  input  logic              bram_axi_wvalid_i,
  output logic              bram_axi_wready_o,
  output logic [1:0]        bram_axi_bresp_o,
  output logic              bram_axi_bvalid_o,
  input  logic              bram_axi_bready_i,
  input  logic [31:0]       bram_axi_araddr_i,
  input  logic              bram_axi_arvalid_i,
  output logic              bram_axi_arready_o,
  output logic [AXI_DW-1:0] bram_axi_rdata_o,
  output logic [1:0]        bram_axi_rresp_o,
  output logic              bram_axi_rvalid_o,
  input  logic              bram_axi_rready_i,
  output logic              bram_en_o,
  output logic [AXI_SW-1:0] bram_we_o,
  output logic [BRAM_AW-1:0] bram_addr_o,
  output logic [AXI_DW-1:0] bram_wdata_o,
  input  logic [AXI_DW-1:0] bram_rdata_i
);

  state_e              state_q, state_d;
  logic                aw_hold_q, aw_hold_d;
  logic [31:2]         aw_addr_q, aw_addr_d;
  logic                w_hold_q, w_hold_d;
  logic [AXI_DW-1:0]   w_data_q, w_data_d;
  logic [AXI_SW-1:0]   w_strb_q, w_strb_d;
  logic [31:2]         ar_addr_q, ar_addr_d;
  grant_e              last_q, last_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                arrdy_q, arrdy_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [AXI_DW-1:0]   rdata_q, rdata_d;

  logic aw_fire;
  logic w_fire;
  logic wr_full;
  logic wr_grant;
  logic ar_ready;
  logic ar_fire;
  logic collide;
  logic aw_ok;
  logic ar_ok;
  logic unused_lsb;

  // Byte-lane bits of the AXI addresses carry no information here.
  assign unused_lsb = ^{bram_axi_awaddr_i[1:0],
                        bram_axi_araddr_i[1:0]};

  // Window decode on the held write and read addresses.
  always_comb begin
    aw_ok = aw_addr_q[31:BRAM_AW+2] == BASE_ADDR[31:BRAM_AW+2];
    ar_ok = ar_addr_q[31:BRAM_AW+2] == BASE_ADDR[31:BRAM_AW+2];
  end

  // Channel handshakes and write-vs-read arbitration.
  always_comb begin
    aw_fire  = bram_axi_awvalid_i && awready_q;
    w_fire   = bram_axi_wvalid_i && wready_q;
    wr_full  = (aw_hold_q || aw_fire) && (w_hold_q || w_fire);
    wr_grant = wr_full
             && !(bram_axi_arvalid_i && last_q == GNT_WRITE);
    ar_ready = arrdy_q && !wr_grant;
    ar_fire  = bram_axi_arvalid_i && ar_ready;
    collide  = wr_full && bram_axi_arvalid_i && arrdy_q;
  end

  // Next-state, holding registers, responses and registered readies.
  always_comb begin
    state_d   = state_q;
    aw_hold_d = aw_hold_q;
    aw_addr_d = aw_addr_q;
    w_hold_d  = w_hold_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_addr_d = ar_addr_q;
    last_d    = last_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (aw_fire) begin
      aw_hold_d = 1'b1;
      aw_addr_d = bram_axi_awaddr_i[31:2];
    end
    if (w_fire) begin
      w_hold_d = 1'b1;
      w_data_d = bram_axi_wdata_i;
      w_strb_d = bram_axi_wstrb_i;
    end
    if (ar_fire) begin
      ar_addr_d = bram_axi_araddr_i[31:2];
    end
    // Only a contested cycle moves the round-robin pointer.
    if (collide) begin
      last_d = wr_grant ? GNT_WRITE : GNT_READ;
    end

    unique case (state_q)
      S_IDLE: begin
        if (ar_fire) begin
          state_d = S_READ;
        end else if (aw_hold_q && w_hold_q) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        aw_hold_d = 1'b0;
        w_hold_d  = 1'b0;
        bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
        state_d   = S_WRESP;
      end
      S_WRESP: begin
        if (bram_axi_bready_i) begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        rdata_d = ar_ok ? bram_rdata_i : '0;
        rresp_d = ar_ok ? RESP_OKAY : RESP_SLVERR;
        state_d = S_RRESP;
      end
      S_RRESP: begin
        if (bram_axi_rready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    awready_d = (state_d == S_IDLE) && !aw_hold_d;
    wready_d  = (state_d == S_IDLE) && !w_hold_d;
    arrdy_d   = (state_d == S_IDLE) && !aw_hold_d && !w_hold_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      aw_hold_q <= 1'b0;
      aw_addr_q <= '0;
      w_hold_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
      last_q    <= GNT_READ;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arrdy_q   <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_hold_q <= aw_hold_d;
      aw_addr_q <= aw_addr_d;
      w_hold_q  <= w_hold_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_addr_q <= ar_addr_d;
      last_q    <= last_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arrdy_q   <= arrdy_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // BRAM port: active only in the WRITE and READ states.
  always_comb begin
    bram_en_o    = 1'b0;
    bram_we_o    = '0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    unique case (state_q)
      S_WRITE: begin
        bram_en_o    = 1'b1;
        bram_we_o    = aw_ok ? w_strb_q : '0;
        bram_addr_o  = aw_addr_q[BRAM_AW+1:2];
        bram_wdata_o = w_data_q;
      end
      S_READ: begin
        bram_en_o   = ar_ok;
        bram_addr_o = ar_addr_q[BRAM_AW+1:2];
      end
      default: begin
      end
    endcase
  end

  assign bram_axi_awready_o = awready_q;
  assign bram_axi_wready_o  = wready_q;
  assign bram_axi_arready_o = ar_ready;
  assign bram_axi_bvalid_o  = state_q == S_WRESP;
  assign bram_axi_bresp_o   = bresp_q;
  assign bram_axi_rvalid_o  = state_q == S_RRESP;
  assign bram_axi_rresp_o   = rresp_q;
  assign bram_axi_rdata_o   = rdata_q;

endmodule

// File: tb/tb_axil_bram_slave.sv
// Directed bench for axil_bram_slave with a byte-lane BRAM model.
// Drives on the falling edge, checks against hand-computed values.
module tb_axil_bram_slave;

  localparam int AW = 10;

  logic          sclk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [31:0]   araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata;
  logic [31:0]   brd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   mem [0:(1<<AW)-1];
  int            we_cnt = 0;
  int            rd_cnt = 0;
  logic [3:0]    last_we = '0;
  logic [AW-1:0] last_wa = '0;

  always #5 sclk = ~sclk;

  axil_bram_slave #(
    .BRAM_AW  (AW),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .sclk              (sclk),
    .reset             (reset),
    .bram_axi_awaddr_i (awaddr),
    .bram_axi_awvalid_i(awvalid),
    .bram_axi_awready_o(awready),
    .bram_axi_wdata_i  (wdata),
    .bram_axi_wstrb_i  (wstrb),
    .bram_axi_wvalid_i (wvalid),
    .bram_axi_wready_o (wready),
    .bram_axi_bresp_o  (bresp),
    .bram_axi_bvalid_o (bvalid),
    .bram_axi_bready_i (bready),
    .bram_axi_araddr_i (araddr),
    .bram_axi_arvalid_i(arvalid),
    .bram_axi_arready_o(arready),
    .bram_axi_rdata_o  (rdata),
    .bram_axi_rresp_o  (rresp),
    .bram_axi_rvalid_o (rvalid),
    .bram_axi_rready_i (rready),
    .bram_en_o         (bram_en),
    .bram_we_o         (bram_we),
    .bram_addr_o       (bram_addr),
    .bram_wdata_o      (bram_wdata),
    .bram_rdata_i      (brd)
  );

  // Read-first single-port BRAM; also logs every port access.
  always @(posedge sclk) begin
    if (bram_en) begin
      if (bram_we == 4'h0) begin
        brd    <= mem[bram_addr];
        rd_cnt <= rd_cnt + 1;
      end else begin
        we_cnt  <= we_cnt + 1;
        last_we <= bram_we;
        last_wa <= bram_addr;
      end
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One clock: note handshakes before the edge, drop satisfied valids.
  task automatic step();
    bit aw_hs, w_hs, ar_hs;
    #1;
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    ar_hs = arvalid && arready;
    @(posedge sclk);
    @(negedge sclk);
    if (aw_hs) awvalid = 1'b0;
    if (w_hs)  wvalid  = 1'b0;
    if (ar_hs) arvalid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int lead,
                    output logic [1:0] resp, output int lat);
    int k;
    if (lead > 0) begin
      wdata = d; wstrb = s; wvalid = 1'b1;
      for (int i = 0; i < lead; i++) step();
    end
    awaddr = a; awvalid = 1'b1;
    if (lead == 0) begin
      wdata = d; wstrb = s; wvalid = 1'b1;
    end
    k = 0;
    while ((awvalid || wvalid) && k < 20) begin
      step(); k++;
    end
    if (awvalid || wvalid) chk("wr_hs_timeout", 32'd0, 32'd1);
    k = 1;
    while (!bvalid && k < 10) begin
      step(); k++;
    end
    if (!bvalid) chk("b_timeout", 32'd0, 32'd1);
    lat  = k;
    resp = bresp;
    if (bready) step();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic [1:0] resp, output int lat);
    int k;
    araddr = a; arvalid = 1'b1;
    k = 0;
    while (arvalid && k < 20) begin
      step(); k++;
    end
    if (arvalid) chk("ar_hs_timeout", 32'd0, 32'd1);
    k = 1;
    while (!rvalid && k < 10) begin
      step(); k++;
    end
    if (!rvalid) chk("r_timeout", 32'd0, 32'd1);
    lat  = k;
    d    = rdata;
    resp = rresp;
    if (rready) step();
  endtask

  // Full write and read presented together; report who answers first.
  task automatic collide(input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] ra,
                         output int bt, output int rt,
                         output logic [31:0] rv);
    awaddr = wa; wdata = wd; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = ra; arvalid = 1'b1;
    bt = -1; rt = -1; rv = '0;
    for (int i = 0; i < 40; i++) begin
      if (bvalid && bt < 0) bt = i;
      if (rvalid && rt < 0) begin
        rt = i; rv = rdata;
      end
      if (bt >= 0 && rt >= 0) break;
      step();
    end
    if (bt < 0 || rt < 0) chk("col_timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int lat, w0, r0, bad, bt, rt;
    logic [31:0] rv;

    repeat (2) @(negedge sclk);
    chk("rst_outputs", 32'({awready, wready, arready, bvalid, rvalid,
         bram_en, bram_we, bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    step();
    chk("rdy_after_rst", 32'({awready, wready, arready}), 32'h7);
    bready = 1'b1; rready = 1'b1;

    // Aligned AW+W full-word write, then readback.
    w0 = we_cnt;
    wr(32'h10, 32'hDEADBEEF, 4'hF, 0, r, lat);
    chk("t1_bresp", 32'(r), 32'd0);
    chk("t1_blat", 32'(lat), 32'd3);
    chk("t1_wcnt", 32'(we_cnt - w0), 32'd1);
    chk("t1_we", 32'(last_we), 32'hF);
    chk("t1_waddr", 32'(last_wa), 32'd4);
    rd(32'h10, d, r, lat);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", 32'(r), 32'd0);
    chk("t1_rlat", 32'(lat), 32'd3);

    // W five cycles ahead of AW, partial strobe merge.
    wr(32'h20, 32'h11223344, 4'hF, 0, r, lat);
    chk("t2_pre_bresp", 32'(r), 32'd0);
    w0 = we_cnt;
    wr(32'h20, 32'hAABBCCDD, 4'b0101, 5, r, lat);
    chk("t2_bresp", 32'(r), 32'd0);
    chk("t2_wcnt", 32'(we_cnt - w0), 32'd1);
    chk("t2_we", 32'(last_we), 32'h5);
    chk("t2_waddr", 32'(last_wa), 32'd8);
    rd(32'h20, d, r, lat);
    chk("t2_rdata", d, 32'h11BB33DD);

    // Zero strobe: OKAY, memory untouched.
    w0 = we_cnt;
    wr(32'h10, 32'h0, 4'h0, 0, r, lat);
    chk("zs_bresp", 32'(r), 32'd0);
    chk("zs_wcnt", 32'(we_cnt - w0), 32'd0);
    rd(32'h10, d, r, lat);
    chk("zs_rdata", d, 32'hDEADBEEF);

    // Outside the window.
    r0 = rd_cnt;
    rd(32'h0000_1000, d, r, lat);
    chk("oor_rresp", 32'(r), 32'h2);
    chk("oor_rdata", d, 32'd0);
    chk("oor_rd_en", 32'(rd_cnt - r0), 32'd0);
    w0 = we_cnt;
    wr(32'h0000_1000, 32'h55555555, 4'hF, 0, r, lat);
    chk("oor_bresp", 32'(r), 32'h2);
    chk("oor_wcnt", 32'(we_cnt - w0), 32'd0);

    // Collisions from reset: write wins, then read wins.
    reset = 1'b1; step();
    reset = 1'b0; step();
    collide(32'h30, 32'hCAFEF00D, 32'h30, bt, rt, rv);
    chk("c1_write_first", 32'(bt < rt), 32'd1);
    chk("c1_rdata", rv, 32'hCAFEF00D);
    collide(32'h30, 32'h12345678, 32'h30, bt, rt, rv);
    chk("c2_read_first", 32'(rt < bt), 32'd1);
    chk("c2_rdata", rv, 32'hCAFEF00D);
    rd(32'h30, d, r, lat);
    chk("c2_after", d, 32'h12345678);

    // Write response back-pressure.
    bready = 1'b0;
    w0 = we_cnt;
    wr(32'h2000, 32'h0BADF00D, 4'hF, 0, r, lat);
    chk("stall_bresp", 32'(r), 32'h2);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bvalid || bresp !== 2'b10 || awready || wready || arready)
        bad++;
      step();
    end
    chk("stall_hold", 32'(bad), 32'd0);
    bready = 1'b1;
    step();
    chk("stall_release", 32'({bvalid, awready, wready, arready}),
        32'h7);
    chk("stall_wcnt", 32'(we_cnt - w0), 32'd0);

    // Reset while a read response is pending.
    rready = 1'b0;
    rd(32'h10, d, r, lat);
    chk("rst_mid_rvalid", 32'(rvalid), 32'd1);
    chk("rst_mid_rdata", d, 32'hDEADBEEF);
    reset = 1'b1;
    step();
    chk("rst_mid_outs", 32'({rvalid, bvalid, awready, wready, arready,
         bram_en}), 32'd0);
    reset = 1'b0;
    rready = 1'b1;
    rd(32'h10, d, r, lat);
    chk("rst_mid_rd", d, 32'hDEADBEEF);
    chk("rst_mid_rresp", 32'(r), 32'd0);
    chk("rst_mid_rlat", 32'(lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/axil_bram_slave.md
Name: axil_bram_slave

Overview:
- AXI4-Lite slave that turns the CPU-side AXI-lite master transactions (the bram_axi_* bundle) into single-port BRAM accesses.
- Sits directly downstream of the CPU AXI-lite master and feeds the packet BRAM shared with the UDP engine.
- One transaction in flight at a time. Fixed-latency read path. Byte-strobed writes.
- Out-of-range addresses are answered with SLVERR.

Parameters:
- BRAM_AW, 10: BRAM word-address width (depth = 2^BRAM_AW 32-bit words).
- BASE_ADDR, 32'h0000_0000: AXI byte base of the window; bits [BRAM_AW+1:0] must be 0.

Ports:
- sclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bram_axi_awaddr_i  in  32  write address.
- bram_axi_awvalid_i  in  1  write address valid.
- bram_axi_awready_o  out  1  write address ready.
- bram_axi_wdata_i  in  32  write data.
- bram_axi_wstrb_i  in  4  write byte strobes.
- bram_axi_wvalid_i  in  1  write data valid.
- bram_axi_wready_o  out  1  write data ready.
- bram_axi_bresp_o  out  2  write response.
- bram_axi_bvalid_o  out  1  write response valid.
- bram_axi_bready_i  in  1  write response ready.
- bram_axi_araddr_i  in  32  read address.
- bram_axi_arvalid_i  in  1  read address valid.
- bram_axi_arready_o  out  1  read address ready.
- bram_axi_rdata_o  out  32  read data.
- bram_axi_rresp_o  out  2  read response.
- bram_axi_rvalid_o  out  1  read data valid.
- bram_axi_rready_i  in  1  read data ready.
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  4  BRAM byte write enables.
- bram_addr_o  out  BRAM_AW  BRAM word address.
- bram_wdata_o  out  32  BRAM write data.
- bram_rdata_i  in  32  BRAM read data; valid the cycle after en with we=0.

Behaviour:
- Clocking and reset:
  - Single clock sclk.
  - Reset is synchronous and active-high on sclk.
  - On reset, all outputs are 0, the state is IDLE, the AW and W holding flags are clear, and last_grant is set to read.
  - A reset asserted mid-transaction abandons that transaction; bvalid/rvalid deassert at that edge.
- States: IDLE, WRITE, WRESP, READ, RWAIT, RRESP.
- AW/W capture in IDLE:
  - AW and W are accepted independently into holding registers with flags aw_hold and w_hold.
  - awready = (state==IDLE) & !aw_hold; wready = (state==IDLE) & !w_hold. Both are registered, not combinational on valid.
  - AW and W may arrive in either order or in the same cycle.
- AR capture in IDLE:
  - arready = (state==IDLE) & !aw_hold & !w_hold & !(write_grant this cycle).
  - A partially captured write blocks reads until the write completes.
- Arbitration, when the write is ready (aw_hold & w_hold) and arvalid in the same cycle:
  - Round-robin on last_grant: the opposite of the last served type wins.
  - A complete write otherwise always proceeds.
- Address decode:
  - in_range = addr[31:BRAM_AW+2] == BASE_ADDR[31:BRAM_AW+2].
  - Word index = addr[BRAM_AW+1:2].
  - Address bits [1:0] are ignored.
- Write path:
  - IDLE→WRITE one cycle after both holds are set.
  - In WRITE: bram_en_o=1, bram_we_o=wstrb (or 0 if out of range), address and data from the holds. Holds clear.
  - →WRESP: bvalid=1, bresp=00 (OKAY) or 10 (SLVERR).
  - bvalid is held until bready; the state then returns to IDLE the cycle after the handshake.
  - wstrb=0 gives en=1, we=0 and OKAY.
- Read path:
  - AR handshake in IDLE → READ: bram_en_o=1, bram_we_o=0 (en=0 if out of range).
  - → RWAIT: bram_rdata_i is captured into the rdata register (0 if out of range).
  - → RRESP: rvalid=1, rresp=OKAY/SLVERR.
  - rvalid and rdata are held stable until rready, then the state returns to IDLE.
  - rvalid rises 3 cycles after the AR handshake cycle.
- Output stability:
  - bram_en_o and bram_we_o are 0 in every state except as stated above.
  - bresp/rresp/rdata are stable while their valid is high.
- Throughput: at most one access every 4 cycles with ready held high.

Decomposition:
- Package axil_pkg holds: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, the state enumeration, and the AXI data/strobe width constants (32/4).
- No sub-module is natural; this is a single module with the FSM, holding registers and address decode inline.

Test Plan:
- Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=F with AW and W in the same cycle, bready=1 → bram_addr_o=4, we=F, one cycle later bvalid, bresp=00. Then read 0x10 with BRAM model returning stored data → rdata=0xDEADBEEF, rresp=00, rvalid 3 cycles after the AR handshake.
- W presented 5 cycles before AW, wstrb=4'b0101 on a word holding 0x11223344, wdata=0xAABBCCDD → single BRAM write with we=0101; readback 0x11BB33DD.
- Read of 0x0000_1000 with BRAM_AW=10 → no bram_en_o, rresp=10, rdata=0. Write to the same address → we never asserted, bresp=10.
- Complete write and arvalid together from reset (last_grant=read) → write served first, read next; repeat the collision → read served first.
- bready held low 20 cycles → bvalid and bresp stable, awready/wready/arready low throughout; handshake completes, then IDLE.
- reset pulsed while in RRESP with rready=0 → next cycle rvalid=0, all readies 0, holds clear. Subsequent transaction completes normally.
